as_gpio_arb: RTL and testbench

- Write arbiter and sequencer for the GPIO output port (gpio_o / gpioAddr_o / cs_o) of the RV64I top.
- Shares the port between two requesters: the core store path (c_*) and the JTAG debug path (d_*).
- Buffers accepted writes in a small FIFO.
- Emits each write as a single-cycle cs_o strobe, with a programmable idle gap between strobes so benches sampling on negedge never miss one.

---
 rtl/as_gpio_arb.sv | 160 ++++++++++++++++
 tb/tb_as_gpio_arb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/as_gpio_arb.sv
// GPIO write arbiter/sequencer: core and debug requesters share one cs_o strobe port via a FIFO.
// Optional macro AS_GPIO_DBG_PRIO_EN gives the debug requester strict priority over the core.
module as_gpio_arb #(
    parameter int nr_gpios        = 64,
    parameter int gpio_addr_width = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int HOLD_CYCLES     = 0,
    localparam int PW             = $clog2(FIFO_DEPTH),
    localparam int LW             = PW + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       c_valid_i,
    input  logic [gpio_addr_width-1:0] c_addr_i,
    input  logic [nr_gpios-1:0]        c_data_i,
    output logic                       c_ready_o,
    input  logic                       d_valid_i,
    input  logic [gpio_addr_width-1:0] d_addr_i,
    input  logic [nr_gpios-1:0]        d_data_i,
    output logic                       d_ready_o,
    output logic [nr_gpios-1:0]        gpio_o,
    output logic [gpio_addr_width-1:0] gpioAddr_o,
    output logic                       cs_o,
    output logic [LW-1:0]              level_o
);

    localparam int EW = gpio_addr_width + nr_gpios;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic                       core_first_q, core_first_d;
    logic [EW-1:0]              mem_q [FIFO_DEPTH];
    logic [PW-1:0]              wptr_q, rptr_q;
    logic [LW-1:0]              level_q, level_d;
    logic [nr_gpios-1:0]        gpio_q;
    logic [gpio_addr_width-1:0] addr_q;

    logic          gnt_c, gnt_d;
    logic          full, empty;
    logic          push, pop;
    logic [EW-1:0] push_entry;

    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign empty = (level_q == '0);

    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
`ifdef AS_GPIO_DBG_PRIO_EN
        if (d_valid_i)      gnt_d = 1'b1;
        else if (c_valid_i) gnt_c = 1'b1;
`else
        if (c_valid_i && d_valid_i) begin
            gnt_c = core_first_q;
            gnt_d = ~core_first_q;
        end else begin
            gnt_c = c_valid_i;
            gnt_d = d_valid_i;
        end
`endif
    end

    // No pop-bypass: a full FIFO refuses even when a strobe pops this cycle.
    assign c_ready_o  = gnt_c & ~full & ~rst_i;
    assign d_ready_o  = gnt_d & ~full & ~rst_i;
    assign push       = c_ready_o | d_ready_o;
    assign push_entry = c_ready_o ? {c_addr_i, c_data_i} : {d_addr_i, d_data_i};

    always_comb begin
        core_first_d = core_first_q;
`ifndef AS_GPIO_DBG_PRIO_EN
        if (c_ready_o)      core_first_d = 1'b0;
        else if (d_ready_o) core_first_d = 1'b1;
`endif
    end

    // Leaving HOLD launches the next strobe directly so the gap is exactly HOLD_CYCLES.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                if (HOLD_CYCLES == 0) begin
                    if (!empty) pop = 1'b1;
                    else        state_d = S_IDLE;
                end else begin
                    cnt_d   = 4'(HOLD_CYCLES);
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_STROBE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= push_entry;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            core_first_q <= 1'b1;
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            gpio_q       <= '0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_first_q <= core_first_d;
            level_q      <= level_d;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop) begin
                rptr_q           <= rptr_q + PW'(1);
                {addr_q, gpio_q} <= mem_q[rptr_q];
            end
        end
    end

    assign cs_o       = (state_q == S_STROBE);
    assign gpio_o     = gpio_q;
    assign gpioAddr_o = addr_q;
    assign level_o    = level_q;

endmodule

// File: tb/tb_as_gpio_arb.sv
// Directed bench for as_gpio_arb: three instances (HOLD_CYCLES 0, 15, 2) share one stimulus.
module tb_as_gpio_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        c_valid = 1'b0, d_valid = 1'b0;
    logic [7:0]  c_addr = '0, d_addr = '0;
    logic [63:0] c_data = '0, d_data = '0;
    logic [2:0]  c_rdy, d_rdy, cs;
    logic [63:0] gpio [3];
    logic [7:0]  addr [3];
    logic [2:0]  lvl  [3];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    as_gpio_arb #(.nr_gpios(64), .gpio_addr_width(8), .FIFO_DEPTH(4), .HOLD_CYCLES(0)) u0 (
        .clk_i(clk), .rst_i(rst),
        .c_valid_i(c_valid), .c_addr_i(c_addr), .c_data_i(c_data), .c_ready_o(c_rdy[0]),
        .d_valid_i(d_valid), .d_addr_i(d_addr), .d_data_i(d_data), .d_ready_o(d_rdy[0]),
        .gpio_o(gpio[0]), .gpioAddr_o(addr[0]), .cs_o(cs[0]), .level_o(lvl[0]));
    as_gpio_arb #(.nr_gpios(64), .gpio_addr_width(8), .FIFO_DEPTH(4), .HOLD_CYCLES(15)) u15 (
        .clk_i(clk), .rst_i(rst),
        .c_valid_i(c_valid), .c_addr_i(c_addr), .c_data_i(c_data), .c_ready_o(c_rdy[1]),
        .d_valid_i(d_valid), .d_addr_i(d_addr), .d_data_i(d_data), .d_ready_o(d_rdy[1]),
        .gpio_o(gpio[1]), .gpioAddr_o(addr[1]), .cs_o(cs[1]), .level_o(lvl[1]));
    as_gpio_arb #(.nr_gpios(64), .gpio_addr_width(8), .FIFO_DEPTH(4), .HOLD_CYCLES(2)) u2 (
        .clk_i(clk), .rst_i(rst),
        .c_valid_i(c_valid), .c_addr_i(c_addr), .c_data_i(c_data), .c_ready_o(c_rdy[2]),
        .d_valid_i(d_valid), .d_addr_i(d_addr), .d_data_i(d_data), .d_ready_o(d_rdy[2]),
        .gpio_o(gpio[2]), .gpioAddr_o(addr[2]), .cs_o(cs[2]), .level_o(lvl[2]));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; c_valid = 1'b0; d_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; c_valid = 1'b1; c_addr = 8'd9; c_data = 64'd9;
        #1;
        checks++;
        if (c_rdy !== 3'b000) begin errors++; $display("FAIL reset_ready_during: got %b want 000", c_rdy); end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cs[i] !== 1'b0 || lvl[i] !== 3'd0 || gpio[i] !== 64'd0 || addr[i] !== 8'd0) begin
                errors++;
                $display("FAIL reset_state[%0d]: cs=%b lvl=%0d gpio=%0h addr=%0h want all 0", i, cs[i], lvl[i], gpio[i], addr[i]);
            end
        end
        c_valid = 1'b0; rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        c_valid = 1'b1; c_addr = 8'd4; c_data = 64'd1;
        #1;
        checks++;
        if (c_rdy[0] !== 1'b1 || d_rdy[0] !== 1'b0) begin errors++; $display("FAIL single_ready: c=%b d=%b want 1 0", c_rdy[0], d_rdy[0]); end
        tick();
        c_valid = 1'b0;
        checks++;
        if (cs[0] !== 1'b0 || lvl[0] !== 3'd1) begin errors++; $display("FAIL single_queued: cs=%b lvl=%0d want 0 1", cs[0], lvl[0]); end
        tick();
        checks++;
        if (cs[0] !== 1'b1 || addr[0] !== 8'd4 || gpio[0] !== 64'd1 || lvl[0] !== 3'd0) begin
            errors++; $display("FAIL single_strobe: cs=%b addr=%0h gpio=%0h lvl=%0d want 1 4 1 0", cs[0], addr[0], gpio[0], lvl[0]);
        end
        tick();
        checks++;
        if (cs[0] !== 1'b0 || gpio[0] !== 64'd1 || addr[0] !== 8'd4) begin
            errors++; $display("FAIL single_after: cs=%b gpio=%0h addr=%0h want 0 1 4", cs[0], gpio[0], addr[0]);
        end
        tick();
        checks++;
        if (gpio[0] !== 64'd1) begin errors++; $display("FAIL single_retain: gpio=%0h want 1", gpio[0]); end
    endtask

    task automatic test_contention();
        logic [63:0] cdat [2];
        logic [63:0] ddat [2];
        logic [63:0] exp_s [4];
        logic [63:0] got [4];
        logic [3:0]  exp_c;
        int ci, di, n, first, last;
        cdat[0] = 64'h3; cdat[1] = 64'h5; ddat[0] = 64'hA; ddat[1] = 64'hB;
`ifdef AS_GPIO_DBG_PRIO_EN
        exp_c = 4'b1100;
        exp_s[0] = 64'hA; exp_s[1] = 64'hB; exp_s[2] = 64'h3; exp_s[3] = 64'h5;
`else
        exp_c = 4'b0101;
        exp_s[0] = 64'h3; exp_s[1] = 64'hA; exp_s[2] = 64'h5; exp_s[3] = 64'hB;
`endif
        ci = 0; di = 0; n = 0; first = -1; last = -1;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            if (cs[0] === 1'b1) begin
                if (n < 4) got[n] = gpio[0];
                n++;
                if (first < 0) first = k;
                last = k;
            end
            c_valid = (ci < 2); c_addr = 8'd1; c_data = cdat[ci % 2];
            d_valid = (di < 2); d_addr = 8'd2; d_data = ddat[di % 2];
            #1;
            if (k < 4) begin
                checks++;
                if (c_rdy[0] !== exp_c[k] || d_rdy[0] !== ~exp_c[k]) begin
                    errors++; $display("FAIL contention_grant[%0d]: c=%b d=%b want c=%b", k, c_rdy[0], d_rdy[0], exp_c[k]);
                end
            end
            if (c_rdy[0] === 1'b1) ci++;
            if (d_rdy[0] === 1'b1) di++;
            tick();
        end
        c_valid = 1'b0; d_valid = 1'b0;
        checks++;
        if (n !== 4 || first !== 2 || last !== 5) begin
            errors++; $display("FAIL contention_strobes: count=%0d first=%0d last=%0d want 4 2 5", n, first, last);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= n || got[i] !== exp_s[i]) begin
                errors++; $display("FAIL contention_order[%0d]: got %0h want %0h", i, (i < n) ? got[i] : 64'hx, exp_s[i]);
            end
        end
    endtask

    task automatic test_full();
        int acc [6];
        int exp_acc [6];
        int wi;
        exp_acc[0] = 0; exp_acc[1] = 1; exp_acc[2] = 2; exp_acc[3] = 3; exp_acc[4] = 4; exp_acc[5] = 18;
        for (int i = 0; i < 6; i++) acc[i] = -1;
        wi = 0;
        do_reset();
        for (int k = 0; k < 25; k++) begin
            c_valid = (wi < 6); c_addr = 8'd7; c_data = 64'(wi + 1);
            #1;
            if (k == 2) begin
                checks++;
                if (cs[1] !== 1'b1 || gpio[1] !== 64'd1) begin errors++; $display("FAIL full_first_strobe: cs=%b gpio=%0h want 1 1", cs[1], gpio[1]); end
            end
            if (k == 5) begin
                checks++;
                if (lvl[1] !== 3'd4 || c_rdy[1] !== 1'b0) begin errors++; $display("FAIL full_level: lvl=%0d ready=%b want 4 0", lvl[1], c_rdy[1]); end
            end
            if (k == 17) begin
                checks++;
                if (c_rdy[1] !== 1'b0) begin errors++; $display("FAIL full_no_bypass: ready=%b want 0", c_rdy[1]); end
            end
            if (k == 18) begin
                checks++;
                if (cs[1] !== 1'b1 || gpio[1] !== 64'd2) begin errors++; $display("FAIL full_second_strobe: cs=%b gpio=%0h want 1 2", cs[1], gpio[1]); end
            end
            if (c_rdy[1] === 1'b1 && wi < 6) begin acc[wi] = k; wi++; end
            tick();
        end
        c_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (acc[i] !== exp_acc[i]) begin errors++; $display("FAIL full_accept[%0d]: cycle %0d want %0d", i, acc[i], exp_acc[i]); end
        end
    endtask

    task automatic test_hold();
        logic [10:0] exp_cs;
        int s;
        exp_cs = 11'b00100100100;
        s = 0;
        do_reset();
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (cs[2] !== exp_cs[k]) begin errors++; $display("FAIL hold_cs[%0d]: got %b want %b", k, cs[2], exp_cs[k]); end
            if (cs[2] === 1'b1) begin
                checks++;
                if (gpio[2] !== 64'(7 + s)) begin errors++; $display("FAIL hold_data[%0d]: got %0h want %0h", s, gpio[2], 7 + s); end
                s++;
            end
            c_valid = (k < 3); c_addr = 8'(k); c_data = 64'(7 + k);
            tick();
        end
        c_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            c_valid = (k < 4); c_addr = 8'h20; c_data = 64'(8'h11 + k);
            tick();
        end
        c_valid = 1'b0;
        checks++;
        if (cs[2] !== 1'b1 || lvl[2] !== 3'd2 || gpio[2] !== 64'h12) begin
            errors++; $display("FAIL rstmid_pre: cs=%b lvl=%0d gpio=%0h want 1 2 12", cs[2], lvl[2], gpio[2]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (cs[2] !== 1'b0 || gpio[2] !== 64'd0 || addr[2] !== 8'd0 || lvl[2] !== 3'd0) begin
            errors++; $display("FAIL rstmid_post: cs=%b gpio=%0h addr=%0h lvl=%0d want 0 0 0 0", cs[2], gpio[2], addr[2], lvl[2]);
        end
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (cs[2] !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: strobe seen=%b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
